stream_demux_ctrl: RTL and testbench
====================================

Name: stream_demux_ctrl

Overview:
- Return-path counterpart of the 2:1 input-streaming mux controller.
- Takes the single result stream leaving the matrix-multiply core and de-interleaves it into two output banks (bank 0 and bank 1).
- Alternates every BURST words, mirroring the input mux phase pattern.
- Generates per-bank write enables and addresses, tracks bank fullness, and back-pressures the core via a valid/ready handshake until downstream releases a full bank.

Parameters:
- DATA_W, 16: width of a streamed result word.
- BURST, 2: consecutive words routed to one bank before switching; must be ≥1.
- DEPTH, 8: words per bank; must be a multiple of BURST.
- ADDR_W, $clog2(DEPTH): bank address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a stream from IDLE.
- in_valid  in  1  core presents a word.
- in_data  in  DATA_W  streamed word.
- in_last  in  1  qualifies the final word of the stream.
- in_ready  out  1  controller accepts a word this cycle.
- wr_en  out  2  one-hot bank write strobe; bit i = bank i.
- wr_addr0  out  ADDR_W  bank 0 write address.
- wr_addr1  out  ADDR_W  bank 1 write address.
- wr_data  out  DATA_W  write data to both banks.
- bank_full  out  2  bank i holds a complete or final-partial block.
- bank_release  in  2  downstream pulse; frees bank i.
- busy  out  1  high in STREAM or STALL.

Behaviour:
- Reset values (async assert): state=IDLE; sel=0; burst_cnt=0; both internal address counters=0; wr_en=00; wr_addr0=wr_addr1=0; wr_data=0; bank_full=00; in_ready=0; busy=0.
- Reset is honoured mid-stream: all of the above apply immediately; any partially written bank is discarded and bank_full is not set.
- States: IDLE, STREAM, STALL.
- IDLE: in_ready=0.
  - start → STREAM next cycle; sel, burst_cnt and address counters are cleared.
  - bank_full is not cleared by start.
- STREAM: in_ready = ~bank_full[sel], combinational.
  - Transfer occurs when in_valid && in_ready.
  - If bank_full[sel] is set at cycle entry, go to STALL.
- STALL: in_ready=0.
  - Return to STREAM the cycle after bank_full[sel] clears.
- start in STREAM or STALL is ignored.
- Transfer, 1-cycle latency, registered outputs on the next edge:
  - wr_en[sel]=1.
  - wr_data=in_data.
  - wr_addrSel = pre-increment counter of bank sel.
  - wr_en is 00 on every cycle without a transfer; wr_data and wr_addr hold their last value.
- Counter update on transfer:
  - addr[sel]++; wraps DEPTH-1 → 0.
  - Write to addr DEPTH-1 sets bank_full[sel].
  - burst_cnt++; at BURST-1, burst_cnt=0 and sel toggles.
- in_last on a transfer:
  - Sets bank_full[sel] (partial block).
  - Clears all counters and sel.
  - Goes to IDLE.
- bank_release[i] clears bank_full[i] at the next edge.
  - Release while bank i is not full: ignored.
  - Release in the same cycle bank_full[i] is being set: set wins.
  - Release of both banks at once is legal.
- Both banks fill in lock-step, so bank 1 normally fills BURST words after bank 0.
- in_valid low inside a burst holds all counters; no bubble penalty.

Test Plan (DEPTH=8, BURST=2, DATA_W=16):
- Reset mid-stream: assert rst after 5 transfers → all outputs at reset values, including wr_en=00 and bank_full=00, in the same cycle; after release, start → words go to bank0 addr0 again.
- Basic de-interleave: start, stream 0x0001..0x0010 with continuous valid → bank0 gets 1,2,5,6,9,10,13,14 at addr 0..7; bank1 gets 3,4,7,8,11,12,15,16; wr_en pattern 01,01,10,10,…; each write lands 1 cycle after its transfer; bank_full 01 then 11; in_ready drops after word 16.
- Back-pressure: after bank_full=11, hold in_valid with 0x0011 → in_ready=0 (STALL).
  - Pulse bank_release=01 → in_ready=1 one cycle after bank_full[0] clears.
  - 0x0011 is written to bank0 addr0.
- Early termination: start, 3 words with in_last on the 3rd → bank0 addr0/1 and bank1 addr0 written; bank_full=10; busy falls; the next start writes bank0 addr0.
- Simultaneous set/release: bank_release[1] pulsed in the same cycle as bank1's final (addr7) write → bank_full[1]=1 after the edge; a release one cycle later clears it.
- Stall bubbles: toggle in_valid every other cycle across a burst boundary → same data/address mapping as the basic de-interleave case; wr_en=00 in idle cycles; busy stays 1; start pulses mid-stream have no effect.

Source files
------------

// File: rtl/stream_demux_ctrl.sv
// stream_demux_ctrl
//   De-interleaves the single result stream leaving the matmul core into two
//   output banks. Words alternate between banks every BURST words; each bank
//   gets its own write address counter. A bank is marked full when its last
//   address is written or when the stream ends on it. The core is
//   back-pressured while the bank currently selected is full, until the
//   downstream consumer releases it.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             pulse, begins a stream from IDLE
//   in_valid/in_ready valid/ready handshake with the core
//   in_data, in_last  streamed word and end-of-stream marker
//   wr_en[1:0]        one-hot bank write strobe (registered)
//   wr_addr0/1        per-bank write address (registered, held between writes)
//   wr_data           write data shared by both banks (registered)
//   bank_full[1:0]    bank holds a complete or final-partial block
//   bank_release[1:0] downstream pulse freeing a bank
//   busy              stream in progress (STREAM or STALL)
module stream_demux_ctrl #(
  parameter int DATA_W = 16,
  parameter int BURST  = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [1:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        bank_full,
  input  logic [1:0]        bank_release,
  output logic              busy
);

  localparam int                BC_W      = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [BC_W-1:0]   BURST_MAX = BC_W'(BURST - 1);

  typedef enum logic [1:0] {IDLE, STREAM, STALL} state_e;

  state_e                 state_q;
  logic                   sel_q;
  logic [BC_W-1:0]        burst_q;
  logic [1:0][ADDR_W-1:0] addr_q;
  logic [1:0]             wr_en_q;
  logic [ADDR_W-1:0]      wr_addr0_q, wr_addr1_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic [1:0]             full_q, full_d, full_set;
  logic [ADDR_W-1:0]      cur_addr;
  logic                   xfer;

  assign cur_addr = addr_q[sel_q];
  assign in_ready = (state_q == STREAM) && !full_q[sel_q];
  assign xfer     = in_valid && in_ready;

  // A set in the same cycle as a release wins, so a bank cannot be freed
  // before its final write has been recorded.
  always_comb begin
    full_set = 2'b00;
    if (xfer && (in_last || cur_addr == ADDR_MAX)) full_set[sel_q] = 1'b1;
    full_d = (full_q & ~bank_release) | full_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      burst_q    <= '0;
      addr_q     <= '0;
      wr_en_q    <= 2'b00;
      wr_addr0_q <= '0;
      wr_addr1_q <= '0;
      wr_data_q  <= '0;
      full_q     <= 2'b00;
    end else begin
      full_q  <= full_d;
      wr_en_q <= 2'b00;
      if (xfer) begin
        wr_en_q   <= sel_q ? 2'b10 : 2'b01;
        wr_data_q <= in_data;
        if (sel_q) wr_addr1_q <= cur_addr;
        else       wr_addr0_q <= cur_addr;
      end
      case (state_q)
        IDLE: if (start) begin
          state_q <= STREAM;
          sel_q   <= 1'b0;
          burst_q <= '0;
          addr_q  <= '0;
        end
        STREAM: begin
          if (xfer) begin
            if (in_last) begin
              state_q <= IDLE;
              sel_q   <= 1'b0;
              burst_q <= '0;
              addr_q  <= '0;
            end else begin
              addr_q[sel_q] <= (cur_addr == ADDR_MAX) ? '0 : cur_addr + ADDR_W'(1);
              if (burst_q == BURST_MAX) begin
                burst_q <= '0;
                sel_q   <= ~sel_q;
              end else begin
                burst_q <= burst_q + BC_W'(1);
              end
            end
          end else if (full_q[sel_q]) begin
            state_q <= STALL;
          end
        end
        // Resume only once the selected bank has been seen empty for a cycle.
        STALL: if (!full_q[sel_q]) state_q <= STREAM;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr0  = wr_addr0_q;
  assign wr_addr1  = wr_addr1_q;
  assign wr_data   = wr_data_q;
  assign bank_full = full_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_stream_demux_ctrl.sv
module tb_stream_demux_ctrl;
  localparam int DW = 16, BURST = 2, DEPTH = 8, AW = 3;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    bank_release = 2'b00;
  logic          in_ready, busy;
  logic [1:0]    wr_en, bank_full;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data;

  stream_demux_ctrl #(.DATA_W(DW), .BURST(BURST), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr0(wr_addr0),
    .wr_addr1(wr_addr1), .wr_data(wr_data), .bank_full(bank_full),
    .bank_release(bank_release), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic [1:0]    wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb_q[$];
  int  sb_k = 0;

  typedef struct packed {
    logic          st, vl, ls;
    logic [DW-1:0] d;
    logic [1:0]    rl;
    logic          rdy;
    logic [1:0]    wren;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] wd;
    logic [1:0]    full;
    logic          busy;
  } vec_t;
  vec_t tbl[$];

  // Test-plan mapping of words 1..16 in the basic de-interleave run.
  int EBANK[16] = '{0,0,1,1,0,0,1,1,0,0,1,1,0,0,1,1};
  int EADDR[16] = '{0,1,0,1,2,3,2,3,4,5,4,5,6,7,6,7};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected bank/address for the k-th accepted word of a stream.
  function automatic sb_t model(input int k, input logic [DW-1:0] d);
    sb_t s;
    int  b;
    b      = (k / BURST) % 2;
    s.wren = (b == 1) ? 2'b10 : 2'b01;
    s.addr = AW'(((k / (2 * BURST)) * BURST + k % BURST) % DEPTH);
    s.data = d;
    return s;
  endfunction

  task automatic sb_check();
    sb_t e;
    if (wr_en != 2'b00) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_write: wr_en=%b with nothing expected at %0t", wr_en, $time);
      end else begin
        e = sb_q.pop_front();
        chk("sb_wr_en", 32'(wr_en), 32'(e.wren));
        chk("sb_wr_addr", 32'(wr_en[1] ? wr_addr1 : wr_addr0), 32'(e.addr));
        chk("sb_wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, predict, clock, score.
  task automatic cyc(input logic st, input logic vl, input logic [DW-1:0] d,
                     input logic ls, input logic [1:0] rl, input logic er);
    start = st; in_valid = vl; in_data = d; in_last = ls; bank_release = rl;
    #1;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (vl && er) begin
      sb_q.push_back(model(sb_k, d));
      sb_k = ls ? 0 : sb_k + 1;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; bank_release = 2'b00;
    sb_check();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
    chk({tag, "_wr_addr0"},  32'(wr_addr0),  32'd0);
    chk({tag, "_wr_addr1"},  32'(wr_addr1),  32'd0);
    chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
    chk({tag, "_bank_full"}, 32'(bank_full), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; bank_release = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    sb_k = 0;
  endtask

  task automatic add(input int st, input int vl, input int d, input int ls, input int rl,
                     input int rdy, input int wren, input int a0, input int a1, input int wd,
                     input int full, input int bsy);
    vec_t v;
    v.st = 1'(st); v.vl = 1'(vl); v.d = DW'(d); v.ls = 1'(ls); v.rl = 2'(rl);
    v.rdy = 1'(rdy); v.wren = 2'(wren); v.a0 = AW'(a0); v.a1 = AW'(a1);
    v.wd = DW'(wd); v.full = 2'(full); v.busy = 1'(bsy);
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ea0, ea1, ef;

    // Basic de-interleave followed by back-pressure and release.
    ea0 = 0; ea1 = 0; ef = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      if (EBANK[k-1] == 1) ea1 = EADDR[k-1]; else ea0 = EADDR[k-1];
      if (k == 14) ef = 1;
      if (k == 16) ef = 3;
      add(0, 1, k, 0, 0, 1, (EBANK[k-1] == 1) ? 2 : 1, ea0, ea1, k, ef, 1);
    end
    add(0, 1, 'h11, 0, 0, 0, 0, ea0, ea1, 16, 3, 1);   // bank0 full: stall
    add(0, 1, 'h11, 0, 1, 0, 0, ea0, ea1, 16, 2, 1);   // release bank0
    add(0, 1, 'h11, 0, 0, 0, 0, ea0, ea1, 16, 2, 1);   // still stalled this cycle
    add(0, 1, 'h11, 0, 0, 1, 1, 0,   ea1, 'h11, 2, 1); // accepted into bank0 addr0
    add(0, 0, 0,    0, 2, 1, 0, 0,   ea1, 'h11, 0, 1); // release bank1

    // Reset state
    #1 rst = 1'b1;
    #1 chk_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-stream after 5 transfers
    sb_k = 0;
    cyc(1, 0, 0, 0, 2'b00, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 1, DW'(16'h0100 + k), 0, 2'b00, 1);
    #2 rst = 1'b1;
    #1 chk_reset("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0; sb_q.delete(); sb_k = 0;
    cyc(1, 0, 0, 0, 2'b00, 0);
    cyc(0, 1, 16'h0abc, 0, 2'b00, 1);
    chk("mid_rst_restart_wr_en", 32'(wr_en), 32'h1);
    chk("mid_rst_restart_addr0", 32'(wr_addr0), 32'h0);

    // Table-driven basic de-interleave / back-pressure
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].vl, tbl[i].d, tbl[i].ls, tbl[i].rl, tbl[i].rdy);
      chk($sformatf("tbl%0d_wr_en", i),     32'(wr_en),     32'(tbl[i].wren));
      chk($sformatf("tbl%0d_wr_addr0", i),  32'(wr_addr0),  32'(tbl[i].a0));
      chk($sformatf("tbl%0d_wr_addr1", i),  32'(wr_addr1),  32'(tbl[i].a1));
      chk($sformatf("tbl%0d_wr_data", i),   32'(wr_data),   32'(tbl[i].wd));
      chk($sformatf("tbl%0d_bank_full", i), 32'(bank_full), 32'(tbl[i].full));
      chk($sformatf("tbl%0d_busy", i),      32'(busy),      32'(tbl[i].busy));
    end

    // Early termination on the 3rd word
    do_reset();
    cyc(1, 0, 0, 0, 2'b00, 0);
    cyc(0, 1, 16'h0021, 0, 2'b00, 1);
    cyc(0, 1, 16'h0022, 0, 2'b00, 1);
    cyc(0, 1, 16'h0023, 1, 2'b00, 1);
    chk("early_wr_en", 32'(wr_en), 32'h2);
    chk("early_addr1", 32'(wr_addr1), 32'h0);
    chk("early_bank_full", 32'(bank_full), 32'h2);
    chk("early_busy", 32'(busy), 32'h0);
    cyc(0, 1, 16'h0024, 0, 2'b00, 0);
    chk("early_idle_wr_en", 32'(wr_en), 32'h0);
    cyc(1, 0, 0, 0, 2'b00, 0);
    chk("early_restart_full_kept", 32'(bank_full), 32'h2);
    chk("early_restart_busy", 32'(busy), 32'h1);
    cyc(0, 1, 16'h0025, 0, 2'b00, 1);
    chk("early_restart_wr_en", 32'(wr_en), 32'h1);
    chk("early_restart_addr0", 32'(wr_addr0), 32'h0);

    // Release in the same cycle bank1's final word is accepted
    do_reset();
    cyc(1, 0, 0, 0, 2'b00, 0);
    for (int k = 1; k <= 16; k++)
      cyc(0, 1, DW'(16'h0030 + k), 0, (k == 16) ? 2'b10 : 2'b00, 1);
    chk("simul_set_wins", 32'(bank_full), 32'h3);
    cyc(0, 0, 0, 0, 2'b10, 0);
    chk("simul_later_release", 32'(bank_full), 32'h1);

    // Valid bubbles across burst boundaries, start ignored mid-stream
    do_reset();
    cyc(1, 0, 0, 0, 2'b00, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, DW'(16'h0040 + k), 0, 2'b00, 1);
      chk($sformatf("bubble_w%0d_busy", k), 32'(busy), 32'h1);
      cyc((k % 3) == 1, 0, 0, 0, 2'b00, 1);
      chk($sformatf("bubble_i%0d_wr_en", k), 32'(wr_en), 32'h0);
      chk($sformatf("bubble_i%0d_busy", k), 32'(busy), 32'h1);
    end
    chk("bubble_last_addr1", 32'(wr_addr1), 32'h3);
    chk("bubble_last_data", 32'(wr_data), 32'h0048);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
